// File: rtl/apb_slave_regfile.sv
// APB4 completer with a bank of NUM_REGS control/status registers; reg 0 is a read-only ID word.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES access-phase wait states on every transfer.
module apb_slave_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B4_0001),
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = ADDR_WIDTH - 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    if ((DATA_WIDTH % 8) != 0 || NUM_REGS < 2 || NUM_REGS > (1 << IDX_WIDTH) ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_param_check
        $error("apb_slave_regfile: parameter out of range");
    end

    logic [0:0]            state_reg;
    logic                  write_reg;
    logic                  err_reg;
    logic [IDX_WIDTH-1:0]  index_reg;
    logic                  pready_reg;
    logic                  pslverr_reg;
    logic [DATA_WIDTH-1:0] prdata_reg;
`ifdef APB_SLV_WAIT_EN
    logic [3:0]            wait_cnt_reg;
`endif

    logic [IDX_WIDTH-1:0]  setup_idx;
    logic [NUM_REGS-1:0]   setup_hit;
    logic                  setup_phase;
    logic                  xfer_live;
    logic                  setup_err;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] setup_rdata;
    logic [DATA_WIDTH-1:0] reg_word [NUM_REGS];

    assign setup_idx   = PADDR[ADDR_WIDTH-1:2];
    assign setup_phase = PSEL & ~PENABLE;
    assign xfer_live   = PSEL & PENABLE;

    // An index beyond the bank hits no register, so the one-hot decode also gives the range check.
    assign setup_err = (PADDR[1:0] != 2'b00) | ~(|setup_hit) | (PWRITE & setup_hit[0]);

    assign wr_fire = (state_reg == ST_ACCESS) & pready_reg & xfer_live & write_reg & ~err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign setup_hit[gi] = (setup_idx == IDX_WIDTH'(gi));

            if (gi == 0) begin : g_id
                assign reg_word[gi] = ID_VALUE;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] value_reg;
                logic                  wr_en;

                assign wr_en = wr_fire & (index_reg == IDX_WIDTH'(gi));

                always_ff @(posedge PCLK) begin
                    if (PRESET) begin
                        value_reg <= '0;
                    end else if (wr_en) begin
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                            if (PSTRB[b]) begin
                                value_reg[8*b +: 8] <= PWDATA[8*b +: 8];
                            end
                        end
                    end
                end

                assign reg_word[gi] = value_reg;
            end
        end
    endgenerate

    always_comb begin
        setup_rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (setup_hit[k]) begin
                setup_rdata = reg_word[k];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= ST_IDLE;
            write_reg    <= 1'b0;
            err_reg      <= 1'b0;
            index_reg    <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            prdata_reg   <= '0;
`ifdef APB_SLV_WAIT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (setup_phase) begin
                        state_reg   <= ST_ACCESS;
                        write_reg   <= PWRITE;
                        err_reg     <= setup_err;
                        index_reg   <= setup_idx;
                        pslverr_reg <= setup_err;
                        prdata_reg  <= (!PWRITE && !setup_err) ? setup_rdata : '0;
`ifdef APB_SLV_WAIT_EN
                        pready_reg   <= (WAIT_CYCLES == 0);
                        wait_cnt_reg <= 4'(WAIT_CYCLES);
`else
                        pready_reg  <= 1'b1;
`endif
                    end
                end
                ST_ACCESS: begin
                    // Completion and protocol abort both return to IDLE with cleared outputs.
                    if (!xfer_live || pready_reg) begin
                        state_reg    <= ST_IDLE;
                        pready_reg   <= 1'b0;
                        pslverr_reg  <= 1'b0;
                        prdata_reg   <= '0;
`ifdef APB_SLV_WAIT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
`ifdef APB_SLV_WAIT_EN
                    else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        if (wait_cnt_reg == 4'd1) begin
                            pready_reg <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign PREADY  = pready_reg;
    assign PRDATA  = prdata_reg;
    assign PSLVERR = pslverr_reg;

endmodule
